// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the single SDRAM controller request interface
// between port 0 (Zorro II, high priority) and port 1 (on-board master).
// The winner's address, direction and strobes are latched for the whole
// controller cycle; port 1 is protected from starvation and every cycle
// is aborted if the controller never acknowledges.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no owner; arbitrate between req0/req1 every edge
// BUSY    | mem_req high, waiting for mem_ack or timeout
// ACKED   | mem_ack seen; ack held until the granted port drops req
// RELEASE | mem_req low; waiting for mem_ack low before freeing the bus

module ram_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 63
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req0,
    input  logic        req1,
    input  logic [22:0] addr0,
    input  logic [22:0] addr1,
    input  logic        rw0,
    input  logic        rw1,
    input  logic        uds0_n,
    input  logic        lds0_n,
    input  logic        uds1_n,
    input  logic        lds1_n,
    output logic        ack0,
    output logic        ack1,
    output logic [1:0]  grant,
    output logic        mem_req,
    output logic [22:0] mem_addr,
    output logic        mem_rw,
    output logic        mem_uds_n,
    output logic        mem_lds_n,
    input  logic        mem_ack,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        ACKED   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [3:0] STARVE_MAX = STARVE_LIMIT[3:0];
    localparam logic [5:0] TIMER_MAX  = TIMEOUT[5:0];

    state_t      state, state_nx;
    logic [3:0]  starve_cnt, starve_cnt_nx;
    logic [5:0]  timer, timer_nx;
    logic [1:0]  grant_nx;
    logic        ack0_nx, ack1_nx;
    logic        mem_req_nx;
    logic [22:0] mem_addr_nx;
    logic        mem_rw_nx, mem_uds_n_nx, mem_lds_n_nx;
    logic        timeout_err_nx;
    logic        gnt_req;

    // State and all outputs are registered; reset abandons any cycle in flight.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            starve_cnt  <= 4'd0;
            timer       <= 6'd0;
            grant       <= 2'b00;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= 23'd0;
            mem_rw      <= 1'b1;
            mem_uds_n   <= 1'b1;
            mem_lds_n   <= 1'b1;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            starve_cnt  <= starve_cnt_nx;
            timer       <= timer_nx;
            grant       <= grant_nx;
            ack0        <= ack0_nx;
            ack1        <= ack1_nx;
            mem_req     <= mem_req_nx;
            mem_addr    <= mem_addr_nx;
            mem_rw      <= mem_rw_nx;
            mem_uds_n   <= mem_uds_n_nx;
            mem_lds_n   <= mem_lds_n_nx;
            timeout_err <= timeout_err_nx;
        end
    end

    // Next-state, arbitration and output decode.
    always_comb begin
        state_nx       = state;
        starve_cnt_nx  = starve_cnt;
        timer_nx       = timer;
        grant_nx       = grant;
        ack0_nx        = ack0;
        ack1_nx        = ack1;
        mem_req_nx     = mem_req;
        mem_addr_nx    = mem_addr;
        mem_rw_nx      = mem_rw;
        mem_uds_n_nx   = mem_uds_n;
        mem_lds_n_nx   = mem_lds_n;
        timeout_err_nx = 1'b0;

        // Request line of whichever port currently owns the controller.
        gnt_req = (grant[0] & req0) | (grant[1] & req1);

        case (state)
            IDLE: begin
                ack0_nx    = 1'b0;
                ack1_nx    = 1'b0;
                mem_req_nx = 1'b0;
                if (req0 && (!req1 || (starve_cnt < STARVE_MAX))) begin
                    mem_addr_nx  = addr0;
                    mem_rw_nx    = rw0;
                    mem_uds_n_nx = uds0_n;
                    mem_lds_n_nx = lds0_n;
                    grant_nx     = 2'b01;
                    mem_req_nx   = 1'b1;
                    timer_nx     = 6'd0;
                    state_nx     = BUSY;
                    // Port 0 only wins over a waiting port 1 below the limit,
                    // so this increment saturates at STARVE_MAX by itself.
                    starve_cnt_nx = req1 ? (starve_cnt + 4'd1) : 4'd0;
                end else if (req1) begin
                    mem_addr_nx   = addr1;
                    mem_rw_nx     = rw1;
                    mem_uds_n_nx  = uds1_n;
                    mem_lds_n_nx  = lds1_n;
                    grant_nx      = 2'b10;
                    mem_req_nx    = 1'b1;
                    timer_nx      = 6'd0;
                    state_nx      = BUSY;
                    starve_cnt_nx = 4'd0;
                end else begin
                    starve_cnt_nx = 4'd0;
                end
            end

            BUSY: begin
                timer_nx = timer + 6'd1;
                if (mem_ack) begin
                    if (gnt_req) begin
                        ack0_nx  = grant[0];
                        ack1_nx  = grant[1];
                        state_nx = ACKED;
                    end else begin
                        // Port walked away mid-cycle: finish silently.
                        mem_req_nx = 1'b0;
                        state_nx   = RELEASE;
                    end
                end else if (timer == TIMER_MAX) begin
                    mem_req_nx     = 1'b0;
                    timeout_err_nx = 1'b1;
                    ack0_nx        = grant[0] & gnt_req;
                    ack1_nx        = grant[1] & gnt_req;
                    state_nx       = RELEASE;
                end
            end

            ACKED: begin
                if (!gnt_req) begin
                    ack0_nx    = 1'b0;
                    ack1_nx    = 1'b0;
                    mem_req_nx = 1'b0;
                    state_nx   = RELEASE;
                end
            end

            RELEASE: begin
                ack0_nx    = 1'b0;
                ack1_nx    = 1'b0;
                mem_req_nx = 1'b0;
                if (!mem_ack) begin
                    grant_nx = 2'b00;
                    state_nx = IDLE;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed vector table plus hand-written sequences
// for starvation, timeout, strobe hold and reset in the middle of a cycle.

module tb_ram_port_arbiter;

    logic        CLK;
    logic        RESET;
    logic        req0, req1;
    logic [22:0] addr0, addr1;
    logic        rw0, rw1;
    logic        uds0_n, lds0_n, uds1_n, lds1_n;
    logic        ack0, ack1;
    logic [1:0]  grant;
    logic        mem_req;
    logic [22:0] mem_addr;
    logic        mem_rw, mem_uds_n, mem_lds_n;
    logic        mem_ack;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    localparam logic [22:0] A0 = 23'h0ABCDE;
    localparam logic [22:0] A1 = 23'h123456;

    ram_port_arbiter #(
        .STARVE_LIMIT(4),
        .TIMEOUT     (63)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .req0       (req0),
        .req1       (req1),
        .addr0      (addr0),
        .addr1      (addr1),
        .rw0        (rw0),
        .rw1        (rw1),
        .uds0_n     (uds0_n),
        .lds0_n     (lds0_n),
        .uds1_n     (uds1_n),
        .lds1_n     (lds1_n),
        .ack0       (ack0),
        .ack1       (ack1),
        .grant      (grant),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rw     (mem_rw),
        .mem_uds_n  (mem_uds_n),
        .mem_lds_n  (mem_lds_n),
        .mem_ack    (mem_ack),
        .timeout_err(timeout_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        r0;
        logic        r1;
        logic        mack;
        logic [1:0]  g;
        logic        mreq;
        logic        a0;
        logic        a1;
        logic [22:0] addr;
    } vec_t;

    vec_t vt [22];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " grant"},       32'(grant),       32'd0);
        check({tag, " mem_req"},     32'(mem_req),     32'd0);
        check({tag, " ack0"},        32'(ack0),        32'd0);
        check({tag, " ack1"},        32'(ack1),        32'd0);
        check({tag, " timeout_err"}, 32'(timeout_err), 32'd0);
        check({tag, " mem_rw"},      32'(mem_rw),      32'd1);
        check({tag, " mem_uds_n"},   32'(mem_uds_n),   32'd1);
        check({tag, " mem_lds_n"},   32'(mem_lds_n),   32'd1);
        check({tag, " mem_addr"},    32'(mem_addr),    32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          r0    r1    mack  grant  mreq  a0    a1    addr
        vt[0]  = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, A1};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, A1};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, A1};
        vt[3]  = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, A1};
        vt[4]  = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, A1};
        vt[5]  = '{1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, A1};
        vt[6]  = '{1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, A1};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, A1};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, A1};
        // early drop of req1 while BUSY
        vt[9]  = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, A1};
        vt[10] = '{1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, A1};
        vt[11] = '{1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, A1};
        vt[12] = '{1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, A1};
        vt[13] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, A1};
        // simultaneous requests: port 0 wins, then port 1
        vt[14] = '{1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, A0};
        vt[15] = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, A0};
        vt[16] = '{1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, A0};
        vt[17] = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, A0};
        vt[18] = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, A1};
        vt[19] = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, A1};
        vt[20] = '{1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, A1};
        vt[21] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, A1};

        RESET   = 1'b1;
        req0    = 1'b0;
        req1    = 1'b0;
        addr0   = A0;
        addr1   = A1;
        rw0     = 1'b1;
        rw1     = 1'b1;
        uds0_n  = 1'b1;
        lds0_n  = 1'b1;
        uds1_n  = 1'b1;
        lds1_n  = 1'b1;
        mem_ack = 1'b0;
        tick();
        tick();
        check_reset_values("reset");
        RESET = 1'b0;
        tick();

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 22; i++) begin
            req0    = vt[i].r0;
            req1    = vt[i].r1;
            mem_ack = vt[i].mack;
            tick();
            check($sformatf("vec%0d grant", i),    32'(grant),    32'(vt[i].g));
            check($sformatf("vec%0d mem_req", i),  32'(mem_req),  32'(vt[i].mreq));
            check($sformatf("vec%0d ack0", i),     32'(ack0),     32'(vt[i].a0));
            check($sformatf("vec%0d ack1", i),     32'(ack1),     32'(vt[i].a1));
            check($sformatf("vec%0d mem_addr", i), 32'(mem_addr), 32'(vt[i].addr));
            check($sformatf("vec%0d tmo", i),      32'(timeout_err), 32'd0);
        end

        // ---------------- starvation: both ports always requesting ----------------
        req0 = 1'b1;
        req1 = 1'b1;
        for (int t = 0; t < 10; t++) begin
            logic [1:0] g;
            logic [1:0] exp_g;
            int w;
            exp_g = ((t == 4) || (t == 9)) ? 2'b10 : 2'b01;
            w = 0;
            while (grant == 2'b00 && w < 10) begin
                tick();
                w++;
            end
            g = grant;
            check($sformatf("starve%0d grant", t), 32'(g), 32'(exp_g));
            mem_ack = 1'b1;
            tick();
            check($sformatf("starve%0d ack0", t), 32'(ack0), 32'(exp_g[0]));
            check($sformatf("starve%0d ack1", t), 32'(ack1), 32'(exp_g[1]));
            if (g[0]) req0 = 1'b0;
            if (g[1]) req1 = 1'b0;
            tick();
            mem_ack = 1'b0;
            req0    = 1'b1;
            req1    = 1'b1;
            tick();
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();
        check("starve end idle grant", 32'(grant), 32'd0);

        // ---------------- timeout: controller never acknowledges ----------------
        begin
            int cnt;
            addr0 = 23'h055AA5;
            req0  = 1'b1;
            tick();
            cnt = 0;
            for (int w = 0; w < 100; w++) begin
                if (!mem_req) break;
                cnt++;
                tick();
            end
            check("tmo mem_req cycles", 32'(cnt), 32'd64);
            check("tmo timeout_err",    32'(timeout_err), 32'd1);
            check("tmo ack0",           32'(ack0), 32'd1);
            check("tmo ack1",           32'(ack1), 32'd0);
            check("tmo grant",          32'(grant), 32'd1);
            req0 = 1'b0;
            tick();
            check("tmo pulse end",      32'(timeout_err), 32'd0);
            check("tmo ack0 end",       32'(ack0), 32'd0);
            check("tmo grant cleared",  32'(grant), 32'd0);
        end

        // ---------------- write strobes held while granted ----------------
        rw0    = 1'b0;
        uds0_n = 1'b0;
        lds0_n = 1'b1;
        addr0  = 23'h2468AC;
        req0   = 1'b1;
        tick();
        check("wr grant", 32'(grant), 32'd1);
        check("wr mem_req", 32'(mem_req), 32'd1);
        rw0    = 1'b1;
        uds0_n = 1'b1;
        lds0_n = 1'b0;
        addr0  = 23'h7FFFFF;
        for (int k = 0; k < 6; k++) begin
            if (k == 3) mem_ack = 1'b1;
            if (k == 4) req0 = 1'b0;
            if (k == 5) mem_ack = 1'b0;
            tick();
            check($sformatf("wr%0d mem_rw", k),    32'(mem_rw),    32'd0);
            check($sformatf("wr%0d mem_uds_n", k), 32'(mem_uds_n), 32'd0);
            check($sformatf("wr%0d mem_lds_n", k), 32'(mem_lds_n), 32'd1);
            check($sformatf("wr%0d mem_addr", k),  32'(mem_addr),  32'h2468AC);
        end
        check("wr end grant", 32'(grant), 32'd0);
        rw0    = 1'b1;
        uds0_n = 1'b1;
        lds0_n = 1'b1;

        // ---------------- reset in the middle of BUSY ----------------
        req1 = 1'b1;
        tick();
        check("rstbusy mem_req", 32'(mem_req), 32'd1);
        check("rstbusy grant",   32'(grant),   32'd2);
        #2;
        RESET = 1'b1;
        #1;
        check_reset_values("rstbusy");
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        req1  = 1'b0;
        tick();
        check("post reset grant", 32'(grant), 32'd0);
        check("post reset mem_req", 32'(mem_req), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-port arbiter and cycle sequencer in front of the SDRAM controller. It shares the single SDRAM controller request interface between port 0 (Zorro II bus, high priority) and port 1 (secondary on-board master, e.g. DMA/memory tester). It latches the winning port's address, direction and strobes, holds them stable for the whole controller cycle, and returns the controller acknowledge to the granted port. Port 1 is protected from starvation, and every cycle has a no-acknowledge timeout.

## Interface
- STARVE_LIMIT, 4: consecutive port-0 grants allowed while port 1 waits (1..15).
- TIMEOUT, 63: BUSY cycles without `mem_ack` before abort (1..63).
- CLK  in  1  system clock; all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  port request; held until the port's ack is seen.
- addr0 / addr1  in  23  word address [23:1].
- rw0 / rw1  in  1  1 = read, 0 = write.
- uds0_n, lds0_n / uds1_n, lds1_n  in  1  byte strobes, active low.
- ack0 / ack1  out  1  cycle acknowledge to the port.
- grant  out  2  one-hot owner, bit 0 = port 0.
- mem_req  out  1  cycle request to the SDRAM controller.
- mem_addr  out  23  latched address.
- mem_rw, mem_uds_n, mem_lds_n  out  1  latched direction and strobes.
- mem_ack  in  1  controller acknowledge (dtack); high until cycle end.
- timeout_err  out  1  one-cycle pulse on timeout abort.

## Operation
- States: IDLE, BUSY, ACKED, RELEASE (2-bit encoding).
- Reset values: state IDLE; ack0/ack1, grant, mem_req, timeout_err = 0; mem_rw = 1; mem_uds_n = mem_lds_n = 1; mem_addr = 0; starve_cnt = 0; timer = 0. RESET during any cycle returns to these values immediately; a half-finished controller cycle is abandoned.
- IDLE arbitration, evaluated each edge:
  - Port 0 wins if req0 && (!req1 || starve_cnt < STARVE_LIMIT).
  - Otherwise port 1 wins if req1.
  - On a win: latch the winner's addr/rw/strobes into mem_*, set grant, set mem_req = 1, clear timer, and go to BUSY.
- starve_cnt (4-bit, saturating at STARVE_LIMIT):
  - +1 when port 0 wins while req1 = 1.
  - Cleared when port 1 wins, or in IDLE when req1 = 0.
- BUSY:
  - Timer increments each cycle.
  - mem_ack = 1: assert ack of the granted port and go to ACKED.
  - Else, timer == TIMEOUT: mem_req = 0, pulse timeout_err, assert the granted port's ack for one cycle, go to RELEASE.
- ACKED:
  - ack held while the granted req = 1.
  - Granted req = 0: ack = 0, mem_req = 0, go to RELEASE.
- RELEASE: ack = 0, mem_req = 0. When mem_ack = 0, clear grant and go to IDLE.
- Granted req dropping in BUSY (protocol violation): the cycle still completes. mem_req stays high until mem_ack or timeout, no ack is issued, then RELEASE.
- mem_addr, mem_rw and strobes change only on an IDLE win; they are constant while grant != 0.
- The non-granted ack is always 0; ack0 && ack1 is never true.

## Timing
- req sampled high in IDLE at edge N: grant, mem_req and mem_* are valid after edge N, i.e. 1-cycle latency.
- mem_ack sampled high at edge M: ackX is high after edge M.
- Granted req sampled low at edge K: mem_req and ackX are low after edge K.
- IDLE is re-entered at the first edge after K with mem_ack = 0. The earliest next grant is the edge after that, giving a minimum gap of 2 cycles with mem_req low.
- Timeout: mem_req is high for exactly TIMEOUT+1 cycles; timeout_err and ackX are high for the single cycle after the abort edge.
- Simultaneous req0 and req1 rising: port 0 wins unless starve_cnt == STARVE_LIMIT.

## Test plan
- Reset/idle: assert RESET mid-BUSY -> all outputs at reset values within the same cycle, mem_rw = 1, grant = 0.
- Single read, port 1: req1 with addr1 = 0x123456, rw1 = 1; mem_ack rises 3 cycles later -> mem_req and grant = 2'b10 one cycle after req1; ack1 one cycle after mem_ack; mem_addr = 0x123456 throughout.
- Starvation: req0 and req1 held continuously, each cycle acked; STARVE_LIMIT = 4 -> grant sequence 0,0,0,0,1,0,0,0,0,1.
- Timeout: req0, mem_ack never rises, TIMEOUT = 63 -> mem_req high for 64 cycles, then timeout_err and ack0 each high for 1 cycle; next grant after RELEASE.
- Write strobes: req0 with rw0 = 0, uds0_n = 0, lds0_n = 1, strobes toggled after grant -> mem_uds_n = 0 and mem_lds_n = 1 held constant until release.
- Early drop: req1 deasserted in BUSY before mem_ack -> ack1 never asserted, mem_req held until mem_ack, RELEASE, then IDLE.
